// File: rtl/tnkiii_shared_ram_arbiter.sv
// tnkiii_shared_ram_arbiter
//   Time-sliced arbiter that lets two CPU requesters (A = main Z80,
//   B = sub Z80) share one synchronous single-port work RAM. One access
//   can start per slot strobe. Each access runs IDLE -> ACCESS -> CAPTURE
//   and ends with a one-clock ack, three clocks after the slot edge.
// Ports
//   i_clk, i_rst        core clock, async active-high reset
//   i_slot_cen          one-clock slot strobe (access start opportunity)
//   i_req_x/i_we_x/i_addr_x/i_wdata_x   requester x level request + payload
//   o_rdata_x/o_ack_x/o_wait_x          requester x read data, ack pulse, wait
//   o_ram_addr/o_ram_we/o_ram_din       registered RAM command
//   i_ram_dout          RAM read data (valid 1 clock after address sampled)
//   o_busy              FSM not idle
module tnkiii_shared_ram_arbiter #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_slot_cen,
  input  logic          i_req_a,
  input  logic          i_we_a,
  input  logic [AW-1:0] i_addr_a,
  input  logic [DW-1:0] i_wdata_a,
  output logic [DW-1:0] o_rdata_a,
  output logic          o_ack_a,
  output logic          o_wait_a,
  input  logic          i_req_b,
  input  logic          i_we_b,
  input  logic [AW-1:0] i_addr_b,
  input  logic [DW-1:0] i_wdata_b,
  output logic [DW-1:0] o_rdata_b,
  output logic          o_ack_b,
  output logic          o_wait_b,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [DW-1:0] o_ram_din,
  input  logic [DW-1:0] i_ram_dout,
  output logic          o_busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;   // 0 = A, 1 = B
  logic          prio_q, prio_d;     // 0 = A, 1 = B
  logic          acc_we_q, acc_we_d; // direction of the access in flight
  logic          armed_a_q, armed_a_d;
  logic          armed_b_q, armed_b_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic [DW-1:0] rdata_a_q, rdata_a_d;
  logic [DW-1:0] rdata_b_q, rdata_b_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;

  logic elig_a, elig_b, pick_b;

  always_comb begin
    elig_a = i_req_a & armed_a_q;
    elig_b = i_req_b & armed_b_q;
    // B wins when it is the only one eligible, or on contention when prio is B
    pick_b = elig_b & (~elig_a | prio_q);

    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    acc_we_d   = acc_we_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = ram_we_q;
    ram_din_d  = ram_din_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_slot_cen && (elig_a || elig_b)) begin
          grant_d    = pick_b;
          ram_addr_d = pick_b ? i_addr_b  : i_addr_a;
          ram_din_d  = pick_b ? i_wdata_b : i_wdata_a;
          ram_we_d   = pick_b ? i_we_b    : i_we_a;
          acc_we_d   = pick_b ? i_we_b    : i_we_a;
          if (elig_a && elig_b) prio_d = ~pick_b;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_we_d = 1'b0;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!acc_we_q) begin
          if (grant_q) rdata_b_d = i_ram_dout;
          else         rdata_a_d = i_ram_dout;
        end
        ack_a_d = ~grant_q;
        ack_b_d = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A low request re-arms; the ack edge disarms so a held request is served once
    armed_a_d = ~i_req_a ? 1'b1 : (ack_a_d ? 1'b0 : armed_a_q);
    armed_b_d = ~i_req_b ? 1'b1 : (ack_b_d ? 1'b0 : armed_b_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      acc_we_q   <= 1'b0;
      armed_a_q  <= 1'b1;
      armed_b_q  <= 1'b1;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      acc_we_q   <= acc_we_d;
      armed_a_q  <= armed_a_d;
      armed_b_q  <= armed_b_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_din_q  <= ram_din_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
    end
  end

  assign o_wait_a   = elig_a;
  assign o_wait_b   = elig_b;
  assign o_rdata_a  = rdata_a_q;
  assign o_rdata_b  = rdata_b_q;
  assign o_ack_a    = ack_a_q;
  assign o_ack_b    = ack_b_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_we   = ram_we_q;
  assign o_ram_din  = ram_din_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule
